// File: rtl/branch_predictor_pkg.sv
// Shared opcode constants and 2-bit saturating counter helper for the
// gshare-style branch predictor.
package branch_predictor_pkg;

  // RISC-V conditional branch major opcode, bits [6:2] of the instruction
  localparam logic [4:0] OPC_BRANCH_5 = 5'b11000;

  typedef logic [1:0] ctr_t;

  function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
    if (taken) return (c == 2'b11) ? c : c + 2'd1;
    else       return (c == 2'b00) ? c : c - 2'd1;
  endfunction

endpackage

// File: rtl/branch_predictor_pattern_table.sv
// Pattern history table: flop array of 2-bit counters with one combinational
// read port and one synchronous saturating-update port.
module pattern_table
  import branch_predictor_pkg::*;
#(
  parameter int   ENTRIES  = 64,
  parameter int   IDX_W    = $clog2(ENTRIES),
  parameter ctr_t CTR_INIT = 2'b01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] i_rd_idx,
  output ctr_t             o_rd_ctr,
  input  logic             i_up_en,
  input  logic [IDX_W-1:0] i_up_idx,
  input  logic             i_up_taken
);

  ctr_t r_ctr [ENTRIES];

  // No bypass: a same-cycle read of the updated entry sees the old value
  assign o_rd_ctr = r_ctr[i_rd_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) r_ctr[i] <= CTR_INIT;
    end else if (i_up_en) begin
      r_ctr[i_up_idx] <= ctr_next(r_ctr[i_up_idx], i_up_taken);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Global-history (gshare) branch predictor: combinational lookup in decode,
// training and statistics on resolution in execute.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int   ENTRIES   = 64,
  parameter int   HIST_BITS = 6,
  parameter ctr_t CTR_INIT  = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] decode_pc,
  input  logic [31:0] decode_inst,
  output logic        predict,
  input  logic        pred_en,
  input  logic        result,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int GW    = (HIST_BITS > 0) ? HIST_BITS : 1;

  logic [GW-1:0]    w_ghr;
  logic [IDX_W-1:0] w_idx;
  logic             w_is_br;
  ctr_t             w_rd_ctr;
  logic [IDX_W-1:0] r_exec_idx;
  logic             r_exec_pred;
  logic [31:0]      r_branch_count;
  logic [31:0]      r_mispredict_count;
  logic             w_unused;

  // History only advances on resolution; a zero-width history is a constant 0
  generate
    if (HIST_BITS > 0) begin : g_hist
      logic [GW-1:0] r_ghr;
      always_ff @(posedge clk) begin
        if (rst)          r_ghr <= '0;
        else if (pred_en) r_ghr <= GW'({r_ghr, result});
      end
      assign w_ghr = r_ghr;
    end else begin : g_nohist
      assign w_ghr = '0;
    end
  endgenerate

  assign w_idx   = decode_pc[IDX_W+1:2] ^ IDX_W'(w_ghr);
  assign w_is_br = (decode_inst[6:2] == OPC_BRANCH_5);

  // While in reset the table is being reinitialised, so report its post-reset value
  assign predict = w_is_br & (rst ? CTR_INIT[1] : w_rd_ctr[1]);

  pattern_table #(
    .ENTRIES  (ENTRIES),
    .IDX_W    (IDX_W),
    .CTR_INIT (CTR_INIT)
  ) u_pt (
    .clk        (clk),
    .rst        (rst),
    .i_rd_idx   (w_idx),
    .o_rd_ctr   (w_rd_ctr),
    .i_up_en    (pred_en),
    .i_up_idx   (r_exec_idx),
    .i_up_taken (result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_exec_idx         <= '0;
      r_exec_pred        <= 1'b0;
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
    end else begin
      r_exec_idx  <= w_idx;
      r_exec_pred <= predict;
      if (pred_en) begin
        r_branch_count <= r_branch_count + 32'd1;
        if (result != r_exec_pred) r_mispredict_count <= r_mispredict_count + 32'd1;
      end
    end
  end

  assign branch_count     = r_branch_count;
  assign mispredict_count = r_mispredict_count;

  assign w_unused = ^{decode_pc[31:IDX_W+2], decode_pc[1:0],
                      decode_inst[31:7], decode_inst[1:0], w_rd_ctr[0]};

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter ENTRIES, default 64, is the number of pattern-table entries and SHALL be a power of two, 4..1024.
REQ-002 Parameter HIST_BITS, default 6, is the global-history width and SHALL satisfy 0 <= HIST_BITS <= log2(ENTRIES).
REQ-003 Parameter CTR_INIT, default 2'b01, is the reset value of every 2-bit counter.
REQ-004 Ports SHALL be, in this order:
- clk  input  1  sole clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- decode_pc  input  32  PC of the instruction in decode.
- decode_inst  input  32  instruction word in decode.
- predict  output  1  taken prediction for the decode instruction.
- pred_en  input  1  a valid conditional branch is resolving in execute this cycle.
- result  input  1  actual outcome of that branch (1 = taken); meaningful only when pred_en=1.
- branch_count  output  32  number of resolved conditional branches.
- mispredict_count  output  32  number of resolved mispredicted branches.

Function
REQ-005 Lookup index SHALL be idx = decode_pc[log2(ENTRIES)+1:2] XOR {zero-extend, ghr}, where ghr is the HIST_BITS global history register.
REQ-006 predict SHALL be combinational: 1 iff decode_inst[6:2] == OPC_BRANCH_5 and counter[idx][1] == 1; otherwise 0. Latency is zero cycles.
REQ-007 On every cycle, exec_idx and exec_pred SHALL register idx and predict, so that they align with the instruction in execute on the next cycle.
REQ-008 When pred_en=1 and result=1, counter[exec_idx] SHALL increment, saturating at 2'b11.
REQ-009 When pred_en=1 and result=0, counter[exec_idx] SHALL decrement, saturating at 2'b00.
REQ-010 When pred_en=1, ghr SHALL shift left by one with result inserted at bit 0. ghr SHALL update only on resolution, never speculatively. With HIST_BITS=0, ghr is absent and idx is the PC bits only.
REQ-011 When pred_en=0, no counter, ghr, or statistic SHALL change.
REQ-012 A lookup and an update to the same entry in the same cycle SHALL read the pre-update value; there is no bypass. The update is visible from the next cycle.
REQ-013 A lookup in the same cycle as a ghr update SHALL use the old ghr.
REQ-014 branch_count SHALL increment by 1 on each cycle with pred_en=1.
REQ-015 mispredict_count SHALL increment by 1 on each cycle with pred_en=1 and result != exec_pred.
REQ-016 Both statistics counters SHALL wrap modulo 2^32 without a sticky flag.
REQ-017 Non-branch instructions in decode SHALL still register exec_idx and exec_pred (exec_pred = 0). Correctness relies on pred_en being asserted only for branches.

Reset
REQ-018 While rst=1 at a clock edge, all counters SHALL be set to CTR_INIT, and ghr, exec_idx, exec_pred, branch_count and mispredict_count SHALL be set to 0. Reset takes effect in that one cycle.
REQ-019 During rst, predict SHALL reflect the post-reset table, i.e. CTR_INIT[1] gated by the opcode check. pred_en asserted together with rst SHALL be ignored.
REQ-020 Reset mid-operation SHALL discard all training; no partial update of the table or ghr.

Structure
REQ-021 Opcode constants (OPC_BRANCH_5) SHALL come from the shared opcode header. No new constants are added there.
REQ-022 The counter array SHALL be a flop array inside sub-module pattern_table: one combinational read port (index, value) and one synchronous saturating-update port (en, index, taken).
REQ-023 ghr, exec_idx/exec_pred and the statistics SHALL reside in branch_predictor.

Verification
REQ-024 Reset, then present BEQ at PC 0x100 -> predict=0 (CTR_INIT=01); branch_count=0.
REQ-025 Resolve PC 0x100 taken twice (HIST_BITS=0) -> counter 01→10→11; next lookup predict=1; a further taken keeps 11.
REQ-026 From 11, resolve not-taken three times -> 10, 01, 00, predict=0; a fourth not-taken keeps 00; mispredict_count increments only on the first two.
REQ-027 Same-cycle lookup and update of the same index, counter=01, result=1 -> predict=0 that cycle, predict=1 the next cycle.
REQ-028 HIST_BITS=2: resolve T, T -> ghr=2'b11; PC 0x100 (idx 0x00) then looks up entry 0x03.
REQ-029 Force branch_count to 0xFFFFFFFF, pulse pred_en -> 0x00000000. Assert rst mid-training -> all counters 01, ghr=0, statistics 0.
